// File: rtl/life_engine.sv
// Conway's Game of Life engine on a toroidal GRID_SIZE x GRID_SIZE grid.
// One cell is evaluated per cycle into a shadow buffer; the whole new
// generation is committed to the visible grid in a single cycle.
//
// Control handshake: pause is a level, not a valid/ready pair. pause high
// holds the engine in edit mode, and while it is high an updatesignal level
// loads gridupdate into grid on that edge in any state. updatesignal is
// ignored while pause is low. step_done is a one-cycle pulse that coincides
// with the first cycle in which the new grid and generation are visible.
module life_engine #(
  parameter int GRID_SIZE = 8,
  parameter int TICK_DIV  = 1000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pause,
  input  logic                           updatesignal,
  input  logic [GRID_SIZE*GRID_SIZE-1:0] gridupdate,
  output logic [GRID_SIZE*GRID_SIZE-1:0] grid,
  output logic [15:0]                    generation,
  output logic                           busy,
  output logic                           step_done
);

  localparam int CELLS = GRID_SIZE * GRID_SIZE;
  localparam int CW    = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] COORD_LAST = CW'(GRID_SIZE - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t            state;
  logic [TW-1:0]     tick;
  logic [CW-1:0]     cx;
  logic [CW-1:0]     cy;
  logic [CELLS-1:0]  shadow;
  logic [IW-1:0]     cell_idx;
  logic [3:0]        nbr_count;
  logic              next_cell;

  // Linear index of the cell currently being evaluated.
  always_comb begin
    cell_idx = IW'(int'(cx) + int'(cy) * GRID_SIZE);
  end

  // Count live neighbours of (cx,cy) with toroidal wrap, then apply B3/S23.
  always_comb begin
    int nx;
    int ny;
    nx        = 0;
    ny        = 0;
    nbr_count = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(cx) + dx;
        ny = int'(cy) + dy;
        if (nx < 0)               nx = nx + GRID_SIZE;
        else if (nx >= GRID_SIZE) nx = nx - GRID_SIZE;
        if (ny < 0)               ny = ny + GRID_SIZE;
        else if (ny >= GRID_SIZE) ny = ny - GRID_SIZE;
        if ((dx != 0) || (dy != 0)) begin
          nbr_count = nbr_count + {3'b000, grid[IW'(nx + ny * GRID_SIZE)]};
        end
      end
    end
    next_cell = (nbr_count == 4'd3) || (grid[cell_idx] && (nbr_count == 4'd2));
  end

  // Sequencer: tick divider in IDLE, cell sweep in COMPUTE, swap in COMMIT.
  // An edit-mode load is applied last so it overrides a same-cycle commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick       <= '0;
      cx         <= '0;
      cy         <= '0;
      shadow     <= '0;
      grid       <= '0;
      generation <= '0;
      busy       <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pause) begin
            tick <= '0;
          end else if (tick == TICK_LAST) begin
            tick  <= '0;
            state <= COMPUTE;
            busy  <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        COMPUTE: begin
          if (pause) begin
            // Abort: the partially filled shadow is simply never committed.
            state <= IDLE;
            busy  <= 1'b0;
            cx    <= '0;
            cy    <= '0;
          end else begin
            shadow[cell_idx] <= next_cell;
            if (cx == COORD_LAST) begin
              cx <= '0;
              if (cy == COORD_LAST) begin
                cy    <= '0;
                state <= COMMIT;
              end else begin
                cy <= cy + 1'b1;
              end
            end else begin
              cx <= cx + 1'b1;
            end
          end
        end
        COMMIT: begin
          grid       <= shadow;
          generation <= generation + 16'd1;
          step_done  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (pause && updatesignal) begin
        grid <= gridupdate;
      end
    end
  end

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine on an 8x8 torus with a short tick divider.
// A cycle-level reference built from whole-generation stepping runs beside
// the DUT; literal patterns (blinker, block, glider) pin the reference.
module tb_life_engine;

  localparam int G = 8;
  localparam int T = 4;
  localparam int N = G * G;

  logic          clk;
  logic          rst_n;
  logic          pause;
  logic          updatesignal;
  logic [N-1:0]  gridupdate;
  logic [N-1:0]  grid;
  logic [15:0]   generation;
  logic          busy;
  logic          step_done;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000; // (2,3),(3,3),(4,3)
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000; // (3,2),(3,3),(3,4)
  localparam logic [63:0] BLOCK_W = 64'h8100_0000_0000_0081; // corners across wrap
  localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402; // (1,0),(2,1),(0..2,2)
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  life_engine #(.GRID_SIZE(G), .TICK_DIV(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pause        (pause),
    .updatesignal (updatesignal),
    .gridupdate   (gridupdate),
    .grid         (grid),
    .generation   (generation),
    .busy         (busy),
    .step_done    (step_done)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference next generation computed directly from the B3/S23 rule.
  function automatic logic [63:0] life_step(input logic [63:0] g);
    logic [63:0] r;
    int n;
    r = '0;
    for (int y = 0; y < G; y++) begin
      for (int x = 0; x < G; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if ((dx != 0) || (dy != 0))
              n = n + int'(g[6'(((x + dx + G) % G) + G * ((y + dy + G) % G))]);
          end
        end
        r[6'(x + G * y)] = (n == 3) || (g[6'(x + G * y)] && (n == 2));
      end
    end
    return r;
  endfunction

  // Reference timeline: a round is T idle cycles, N sweep cycles, one commit.
  // Pause restarts the round unless the commit cycle has already been reached.
  logic [63:0] m_grid;
  logic [15:0] m_gen;
  logic        m_done;
  int          m_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_grid <= '0;
      m_gen  <= '0;
      m_done <= 1'b0;
      m_cyc  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cyc == T + N) begin
        m_grid <= (pause && updatesignal) ? gridupdate : life_step(m_grid);
        m_gen  <= m_gen + 16'd1;
        m_done <= 1'b1;
        m_cyc  <= 0;
      end else begin
        m_cyc <= pause ? 0 : m_cyc + 1;
        if (pause && updatesignal) m_grid <= gridupdate;
      end
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      total = total + 4;
      if (grid !== m_grid) begin
        bad++;
        $display("FAIL cyc_grid t=%0t: got %h want %h", $time, grid, m_grid);
      end
      if (generation !== m_gen) begin
        bad++;
        $display("FAIL cyc_gen t=%0t: got %0d want %0d", $time, generation, m_gen);
      end
      if (busy !== (m_cyc >= T)) begin
        bad++;
        $display("FAIL cyc_busy t=%0t: got %b want %b", $time, busy, (m_cyc >= T));
      end
      if (step_done !== m_done) begin
        bad++;
        $display("FAIL cyc_step_done t=%0t: got %b want %b", $time, step_done, m_done);
      end
    end
  end

  // step_done pulse statistics
  int  pulses     = 0;
  int  high_cyc   = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (step_done) high_cyc++;
      if (step_done && !prev_done) pulses++;
      prev_done <= step_done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Driver and check tasks
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    pause        = 1'b1;
    updatesignal = 1'b0;
    gridupdate   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [63:0] g);
    @(negedge clk);
    pause        = 1'b1;
    updatesignal = 1'b1;
    gridupdate   = g;
    @(negedge clk);
    updatesignal = 1'b0;
  endtask

  task automatic wait_gen(input logic [15:0] target, input int budget, input string name);
    int n;
    n = 0;
    while ((generation !== target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (generation !== target) begin
      bad++;
      $display("FAIL %s: got gen %0d want %0d within %0d cycles", name, generation, target, budget);
    end
  endtask

  task automatic wait_busy(input int budget, input string name);
    int n;
    n = 0;
    while ((busy !== 1'b1) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s: busy never rose within %0d cycles", name, budget);
    end
  endtask

  // Directed scenarios
  initial begin
    rst_n        = 1'b0;
    pause        = 1'b1;
    updatesignal = 1'b0;
    gridupdate   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check64("reset_grid", grid, 64'h0);
    check64("reset_gen", 64'(generation), 64'h0);
    check64("reset_busy", 64'(busy), 64'h0);
    check64("reset_step_done", 64'(step_done), 64'h0);

    // updatesignal ignored without pause, honoured with pause
    pause        = 1'b0;
    updatesignal = 1'b1;
    gridupdate   = ONES;
    @(negedge clk);
    check64("load_ignored", grid, 64'h0);
    pause = 1'b1;
    @(negedge clk);
    check64("load_taken", grid, ONES);
    updatesignal = 1'b0;

    // All-dead grid still steps
    load(64'h0);
    pause = 1'b0;
    wait_gen(16'd1, 200, "dead_wait");
    check64("dead_grid", grid, 64'h0);
    check64("dead_gen", 64'(generation), 64'd1);
    pause = 1'b1;

    // Blinker
    do_reset();
    load(BLINK_H);
    pause = 1'b0;
    wait_gen(16'd1, 200, "blink_wait1");
    check64("blink_gen1_grid", grid, BLINK_V);
    check64("blink_gen1_gen", 64'(generation), 64'd1);
    wait_gen(16'd2, 200, "blink_wait2");
    check64("blink_gen2_grid", grid, BLINK_H);
    check64("blink_gen2_gen", 64'(generation), 64'd2);
    pause = 1'b1;

    // Block still life across the wrap corner
    do_reset();
    load(BLOCK_W);
    pulses   = 0;
    high_cyc = 0;
    pause    = 1'b0;
    wait_gen(16'd3, 400, "block_wait");
    pause = 1'b1;
    repeat (2) @(negedge clk);
    check64("block_grid", grid, BLOCK_W);
    check64("block_gen", 64'(generation), 64'd3);
    check64("block_pulses", 64'(pulses), 64'd3);
    check64("block_high_cycles", 64'(high_cyc), 64'd3);

    // Pause 10 cycles into the sweep aborts the step
    do_reset();
    load(BLINK_H);
    pulses = 0;
    pause  = 1'b0;
    wait_busy(20, "abort_busy");
    repeat (10) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    check64("abort_busy_drop", 64'(busy), 64'h0);
    check64("abort_grid", grid, BLINK_H);
    check64("abort_gen", 64'(generation), 64'h0);
    repeat (80) @(negedge clk);
    check64("abort_no_pulse", 64'(pulses), 64'h0);

    // Pause plus load landing exactly on the commit cycle
    do_reset();
    load(BLINK_H);
    pause = 1'b0;
    wait_busy(20, "commit_busy");
    repeat (N) @(negedge clk);
    pause        = 1'b1;
    updatesignal = 1'b1;
    gridupdate   = GLIDER;
    @(negedge clk);
    updatesignal = 1'b0;
    check64("commit_load_grid", grid, GLIDER);
    check64("commit_load_gen", 64'(generation), 64'd1);
    check64("commit_load_done", 64'(step_done), 64'd1);

    // Asynchronous reset in the middle of a sweep
    do_reset();
    load(BLOCK_W);
    pause = 1'b0;
    wait_busy(20, "rst_busy");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check64("rst_grid", grid, 64'h0);
    check64("rst_gen", 64'(generation), 64'h0);
    check64("rst_busy", 64'(busy), 64'h0);
    check64("rst_step_done", 64'(step_done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      check64($sformatf("rst_release_busy_%0d", k), 64'(busy), 64'((k == T) ? 1 : 0));
    end

    // Glider returns home after 32 generations on the torus
    do_reset();
    load(GLIDER);
    pause = 1'b0;
    wait_gen(16'd32, 32 * (T + N + 1) + 200, "glider_wait");
    pause = 1'b1;
    @(negedge clk);
    check64("glider_grid", grid, GLIDER);
    check64("glider_gen", 64'(generation), 64'd32);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
